lsu_mem_responder: RTL and testbench

Memory-side responder for the LSU data bus: accepts word-aligned requests with byte selects from the load/store unit, performs them on an internal synchronous word RAM after a programmable number of wait states, and terminates each access with a one-cycle acknowledge or error. It sits between the LSU bus and the data memory region and is the slave end of the lsu_addr/lsu_dat/lsu_sel/lsu_we/lsu_re interface.

---
 rtl/lsu_mem_responder.sv | 122 ++++++++++++
 tb/tb_lsu_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_responder.sv
// LSU data-bus memory responder: word RAM with byte lanes, programmable wait
// states, and a one-cycle ack/err termination per access.
module lsu_mem_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_dat_i,
  input  logic [3:0]  lsu_sel_i,
  input  logic        lsu_we_i,
  input  logic        lsu_re_i,
  output logic [31:0] lsu_dat_o,
  output logic        lsu_ack_o,
  output logic        lsu_err_o
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic        active;
  logic        capture, enter_resp;

  logic [31:0] cap_addr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;

  logic [31:0]           acc_addr, acc_dat;
  logic [3:0]            acc_sel;
  logic                  acc_we, acc_ok;
  logic [DEPTH_LOG2-1:0] acc_idx;

  logic [31:0] mem [DEPTH];

  // With zero wait states the access completes on the capture edge, so the
  // live bus is used in IDLE and the captured copy afterwards.
  always_comb begin
    acc_addr = (state == IDLE) ? lsu_addr_i : cap_addr;
    acc_dat  = (state == IDLE) ? lsu_dat_i  : cap_dat;
    acc_sel  = (state == IDLE) ? lsu_sel_i  : cap_sel;
    acc_we   = (state == IDLE) ? lsu_we_i   : cap_we;
    acc_ok   = (acc_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]) &&
               (acc_addr[1:0] == 2'b00);
    acc_idx  = acc_addr[DEPTH_LOG2+1:2];
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    capture       = 1'b0;
    enter_resp    = 1'b0;
    case (state)
      IDLE: begin
        if (active && (lsu_we_i || lsu_re_i)) begin
          capture       = 1'b1;
          wait_cnt_next = WAIT_LOAD;
          if (HAS_WAIT) begin
            state_next = WAIT;
          end else begin
            state_next = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Requests are not taken until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      active    <= 1'b0;
      cap_addr  <= 32'h0;
      cap_dat   <= 32'h0;
      cap_sel   <= 4'h0;
      cap_we    <= 1'b0;
      lsu_ack_o <= 1'b0;
      lsu_err_o <= 1'b0;
      lsu_dat_o <= 32'h0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      active    <= 1'b1;
      if (capture) begin
        cap_addr <= lsu_addr_i;
        cap_dat  <= lsu_dat_i;
        cap_sel  <= lsu_sel_i;
        cap_we   <= lsu_we_i;
      end
      lsu_ack_o <= enter_resp && acc_ok;
      lsu_err_o <= enter_resp && !acc_ok;
      if (enter_resp && !acc_we)
        lsu_dat_o <= acc_ok ? mem[acc_idx] : 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enter_resp && acc_we && acc_ok) begin
      for (int i = 0; i < 4; i++)
        if (acc_sel[i]) mem[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: main instance with one wait state,
// plus zero-wait and three-wait instances for back-to-back and reset cases.
module tb_lsu_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] addr, wdat;
  logic [3:0]  sel;
  logic        we_a, re_a, we_b, re_b, we_c, re_c;
  logic [31:0] dat_a, dat_b, dat_c;
  logic        ack_a, err_a, ack_b, err_b, ack_c, err_c;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          due;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_mem [0:1023];
  logic [31:0] last_rd;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  lsu_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .lsu_addr_i(addr), .lsu_dat_i(wdat),
    .lsu_sel_i(sel), .lsu_we_i(we_a), .lsu_re_i(re_a),
    .lsu_dat_o(dat_a), .lsu_ack_o(ack_a), .lsu_err_o(err_a));

  lsu_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .lsu_addr_i(addr), .lsu_dat_i(wdat),
    .lsu_sel_i(sel), .lsu_we_i(we_b), .lsu_re_i(re_b),
    .lsu_dat_o(dat_b), .lsu_ack_o(ack_b), .lsu_err_o(err_b));

  lsu_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .lsu_addr_i(addr), .lsu_dat_i(wdat),
    .lsu_sel_i(sel), .lsu_we_i(we_c), .lsu_re_i(re_c),
    .lsu_dat_o(dat_c), .lsu_ack_o(ack_c), .lsu_err_o(err_c));

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Any ack/err from the main instance must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_i && (ack_a || err_a)) begin
      if (sb.size() == 0) begin
        check_output("unexpected_resp", {30'h0, ack_a, err_a}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check_output({mon_e.tag, "_ack"}, 32'(ack_a), 32'(mon_e.ack));
        check_output({mon_e.tag, "_err"}, 32'(err_a), 32'(mon_e.err));
        check_output({mon_e.tag, "_dat"}, dat_a, mon_e.dat);
        check_output({mon_e.tag, "_cycle"}, cyc, mon_e.due);
      end
    end
  end

  task automatic apply_stimulus(input string tag, input logic we, input logic re,
                                input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int   idx;
    logic ok;
    @(negedge clk_i);
    addr = a; wdat = d; sel = s; we_a = we; re_a = re;
    idx   = int'(a[11:2]);
    ok    = (a[31:12] == 20'h0) && (a[1:0] == 2'b00);
    e.tag = tag;
    e.due = cyc + 2;
    e.ack = ok;
    e.err = !ok;
    if (we) begin
      if (ok)
        for (int i = 0; i < 4; i++)
          if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
      e.dat = last_rd;
    end else begin
      e.dat   = ok ? model_mem[idx] : 32'h0;
      last_rd = e.dat;
    end
    sb.push_back(e);
    @(posedge clk_i); #1;
    we_a = 1'b0; re_a = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk_i); #1;
    end
    check_output({tag, "_pending"}, sb.size(), 32'h0);
    sb.delete();
  endtask

  task automatic access_c(input string tag, input logic we, input logic re,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] want_dat);
    int k;
    @(negedge clk_i);
    addr = a; wdat = d; sel = s; we_c = we; re_c = re;
    @(posedge clk_i); #1;
    we_c = 1'b0; re_c = 1'b0;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!(ack_c || err_c) && k < 20);
    check_output({tag, "_lat"}, k, 32'd4);
    check_output({tag, "_ack"}, 32'(ack_c), 32'd1);
    check_output({tag, "_dat"}, dat_c, want_dat);
  endtask

  initial begin
    int acks;
    logic [31:0] a;
    addr = 0; wdat = 0; sel = 0;
    we_a = 0; re_a = 0; we_b = 0; re_b = 0; we_c = 0; re_c = 0;
    last_rd = 32'h0;
    repeat (3) @(negedge clk_i);
    check_output("rst_dat_a", dat_a, 32'h0);
    check_output("rst_flags_a", {30'h0, ack_a, err_a}, 32'h0);
    check_output("rst_flags_b", {30'h0, ack_b, err_b}, 32'h0);
    check_output("rst_flags_c", {30'h0, ack_c, err_c}, 32'h0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    apply_stimulus("wr_word",  1, 0, 32'h10, 32'hDEADBEEF, 4'b1111);
    apply_stimulus("rd_word",  0, 1, 32'h10, 32'h0,        4'b0001);
    apply_stimulus("pre_20",   1, 0, 32'h20, 32'h00000000, 4'b1111);
    apply_stimulus("wr_byte",  1, 0, 32'h20, 32'hABABABAB, 4'b0100);
    apply_stimulus("rd_byte",  0, 1, 32'h20, 32'h0,        4'b1111);
    apply_stimulus("wr_nosel", 1, 0, 32'h20, 32'hFFFFFFFF, 4'b0000);
    apply_stimulus("rd_nosel", 0, 1, 32'h20, 32'h0,        4'b1111);
    apply_stimulus("pre_24",   1, 0, 32'h24, 32'hFFFFFFFF, 4'b1111);
    apply_stimulus("wr_half",  1, 0, 32'h24, 32'h12341234, 4'b1100);
    apply_stimulus("rd_half",  0, 1, 32'h24, 32'h0,        4'b0011);
    apply_stimulus("rd_oor",   0, 1, 32'h1000, 32'h0,      4'b1111);
    apply_stimulus("wr_mis",   1, 0, 32'h13, 32'h77777777, 4'b1111);
    apply_stimulus("rd_after", 0, 1, 32'h10, 32'h0,        4'b1111);
    apply_stimulus("wr_both",  1, 1, 32'h28, 32'h0BADF00D, 4'b1111);
    apply_stimulus("rd_both",  0, 1, 32'h28, 32'h0,        4'b1111);
    apply_stimulus("rd_hioor", 0, 1, 32'h8000_0010, 32'h0, 4'b1111);

    for (int i = 0; i < 4; i++)
      apply_stimulus("fill", 1, 0, 32'h100 + 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 12; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 1) == 1)
        apply_stimulus("rnd_wr", 1, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
      else
        apply_stimulus("rnd_rd", 0, 1, a, 32'h0, 4'($urandom));
    end

    // Zero-wait instance with the request held for four cycles.
    @(negedge clk_i);
    addr = 32'h40; wdat = 32'hCAFEF00D; sel = 4'hF; we_b = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check_output("b2b_ack", 32'(ack_b), 32'(i == 0 || i == 2));
      acks += int'(ack_b);
    end
    we_b = 1'b0;
    @(negedge clk_i);
    check_output("b2b_tail", {30'h0, ack_b, err_b}, 32'h0);
    check_output("b2b_count", acks, 32'd2);
    re_b = 1'b1;
    @(posedge clk_i); #1;
    re_b = 1'b0;
    @(negedge clk_i);
    check_output("b2b_rd_ack", 32'(ack_b), 32'd1);
    check_output("b2b_rd_dat", dat_b, 32'hCAFEF00D);

    // Three-wait instance: reset during WAIT aborts the write.
    access_c("c_wr", 1, 0, 32'h30, 32'h11111111, 4'hF, 32'h0);
    access_c("c_rd", 0, 1, 32'h30, 32'h0,        4'hF, 32'h11111111);
    @(negedge clk_i);
    addr = 32'h30; wdat = 32'h55555555; sel = 4'hF; we_c = 1'b1;
    @(posedge clk_i); #1;
    we_c = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_output("c_rst_flags", {30'h0, ack_c, err_c}, 32'h0);
    check_output("c_rst_dat", dat_c, 32'h0);
    check_output("a_rst_dat", dat_a, 32'h0);
    last_rd = 32'h0;
    @(negedge clk_i);
    rst_i = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk_i);
      acks += int'(ack_c | err_c);
    end
    check_output("c_no_ack", acks, 32'd0);
    access_c("c_rd_old", 0, 1, 32'h30, 32'h0, 4'hF, 32'h11111111);
    apply_stimulus("a_post_rst", 0, 1, 32'h10, 32'h0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
